// File: rtl/lab3_cache_mem_pkg.sv
// Message formats shared by the cache memory responder and its requesters.
// mem_req_4B_t  : type, opaque tag, byte address, length code, write data.
// mem_resp_4B_t : type, opaque tag, test bits, length code, read data.
// Length code: 0 means a full 4-byte word, 1..3 mean that many bytes.
package lab3_cache_mem_pkg;

    localparam logic [2:0] TypeRead   = 3'd0;
    localparam logic [2:0] TypeWrite  = 3'd1;
    localparam logic [2:0] TypeInit   = 3'd2;
    localparam logic [2:0] TypeAmoAdd = 3'd3;

    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

endpackage

// File: rtl/lab3_cache_mem_responder.sv
// Blocking single-outstanding memory responder with word-organised backing storage.
// One request is accepted in IDLE, the response appears LATENCY+1 cycles after the
// accept edge and is held until the requester takes it.
//
// Ports:
//   clk          sole clock, rising edge
//   reset        asynchronous, active-low
//   memreq_val   request valid          memreq_rdy   responder idle and out of reset
//   memreq_msg   request message
//   memresp_val  response valid         memresp_rdy  requester takes the response
//   memresp_msg  response message (held stable while memresp_val is high)
module lab3_cache_mem_responder
    import lab3_cache_mem_pkg::*;
#(
    parameter int unsigned NUM_WORDS = 256,
    parameter int unsigned LATENCY   = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         memreq_val,
    output logic         memreq_rdy,
    input  mem_req_4B_t  memreq_msg,
    output logic         memresp_val,
    input  logic         memresp_rdy,
    output mem_resp_4B_t memresp_msg
);

    localparam int unsigned IdxW     = $clog2(NUM_WORDS);
    localparam logic [3:0]  WaitLoad = (LATENCY >= 1) ? 4'(LATENCY - 1) : 4'd0;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    // Holds memreq_rdy low until the first clock edge after reset is released.
    logic        live_q;

    logic [2:0]  type_q;
    logic [7:0]  opaque_q;
    logic [1:0]  len_q;
    logic [31:0] data_q;

    // Storage is deliberately not reset; contents survive a reset pulse.
    logic [31:0] mem_q [NUM_WORDS];

    logic            accept;
    logic            is_read;
    logic            is_write;
    logic [IdxW-1:0] idx;
    logic [1:0]      off;
    logic [3:0]      len_mask;
    logic [3:0]      byte_en;
    logic [31:0]     cur_word;
    logic [31:0]     wr_shift;
    logic [31:0]     wr_word;
    logic [31:0]     rd_shift;
    logic [31:0]     rd_mask;
    logic [31:0]     rd_data;

    // Address bits above the word index alias onto the same storage.
    logic unused_addr;
    assign unused_addr = ^memreq_msg.addr[31:2+IdxW];

    assign accept   = memreq_val & memreq_rdy;
    assign is_read  = (memreq_msg.type_ == TypeRead);
    assign is_write = (memreq_msg.type_ == TypeWrite) || (memreq_msg.type_ == TypeInit);
    assign idx      = memreq_msg.addr[2 +: IdxW];
    assign off      = memreq_msg.addr[1:0];
    assign cur_word = mem_q[idx];

    // Bytes covered by the request, relative to the byte offset.
    always_comb begin
        len_mask = 4'b1111;
        unique case (memreq_msg.len)
            2'd0: len_mask = 4'b1111;
            2'd1: len_mask = 4'b0001;
            2'd2: len_mask = 4'b0011;
            2'd3: len_mask = 4'b0111;
        endcase
    end

    // Shifting left by the offset naturally drops bytes that run past byte 3.
    assign byte_en  = len_mask << off;
    assign wr_shift = memreq_msg.data << {off, 3'b000};

    always_comb begin
        wr_word = cur_word;
        for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) begin
                wr_word[8*b +: 8] = wr_shift[8*b +: 8];
            end
        end
    end

    assign rd_shift = cur_word >> {off, 3'b000};

    always_comb begin
        rd_mask = '0;
        for (int b = 0; b < 4; b++) begin
            rd_mask[8*b +: 8] = {8{len_mask[b]}};
        end
    end

    assign rd_data = rd_shift & rd_mask;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = WaitLoad;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (memresp_rdy) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            live_q   <= 1'b0;
            type_q   <= 3'd0;
            opaque_q <= 8'd0;
            len_q    <= 2'd0;
            data_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            live_q  <= 1'b1;
            if (accept) begin
                type_q   <= memreq_msg.type_;
                opaque_q <= memreq_msg.opaque;
                len_q    <= memreq_msg.len;
                // Read data is sampled at accept so later writes cannot disturb it.
                data_q   <= is_read ? rd_data : 32'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && is_write) begin
            mem_q[idx] <= wr_word;
        end
    end

    assign memreq_rdy  = live_q && (state_q == StIdle);
    assign memresp_val = (state_q == StResp);

    always_comb begin
        memresp_msg        = '0;
        memresp_msg.type_  = type_q;
        memresp_msg.opaque = opaque_q;
        memresp_msg.test   = 2'd0;
        memresp_msg.len    = len_q;
        memresp_msg.data   = data_q;
    end

endmodule

// File: tb/tb_lab3_cache_mem_responder.sv
// Bench for lab3_cache_mem_responder: one instance with LATENCY=2, one with LATENCY=0,
// both NUM_WORDS=256, checked against a byte-level storage model.
module tb_lab3_cache_mem_responder;
    import lab3_cache_mem_pkg::*;

    localparam int Words = 256;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         req_val  [2];
    logic         req_rdy  [2];
    mem_req_4B_t  req_msg  [2];
    logic         resp_val [2];
    logic         resp_rdy [2];
    mem_resp_4B_t resp_msg [2];

    int          lat [2] = '{2, 0};
    logic [31:0] model [2][Words];
    int          last_acc [2];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lab3_cache_mem_responder #(.NUM_WORDS(256), .LATENCY(2)) dut_l2 (
        .clk         (clk),
        .reset       (reset),
        .memreq_val  (req_val[0]),
        .memreq_rdy  (req_rdy[0]),
        .memreq_msg  (req_msg[0]),
        .memresp_val (resp_val[0]),
        .memresp_rdy (resp_rdy[0]),
        .memresp_msg (resp_msg[0])
    );

    lab3_cache_mem_responder #(.NUM_WORDS(256), .LATENCY(0)) dut_l0 (
        .clk         (clk),
        .reset       (reset),
        .memreq_val  (req_val[1]),
        .memreq_rdy  (req_rdy[1]),
        .memreq_msg  (req_msg[1]),
        .memresp_val (resp_val[1]),
        .memresp_rdy (resp_rdy[1]),
        .memresp_msg (resp_msg[1])
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference storage: byte k of the request lands at byte offset+k of the word.
    function automatic logic [31:0] model_read(input int d, input logic [31:0] a,
                                               input logic [1:0] ln);
        int          nb  = (ln == 2'd0) ? 4 : int'(ln);
        int          off = int'(a % 4);
        logic [31:0] w   = model[d][(a / 4) % Words];
        logic [31:0] r   = '0;
        for (int k = 0; k < nb; k++) begin
            if (off + k < 4) r[8*k +: 8] = w[8*(off+k) +: 8];
        end
        return r;
    endfunction

    task automatic model_write(input int d, input logic [31:0] a, input logic [1:0] ln,
                               input logic [31:0] dat);
        int nb  = (ln == 2'd0) ? 4 : int'(ln);
        int off = int'(a % 4);
        int w   = int'((a / 4) % Words);
        for (int k = 0; k < nb; k++) begin
            if (off + k < 4) model[d][w][8*(off+k) +: 8] = dat[8*k +: 8];
        end
    endtask

    // One full transaction on instance d; hold = cycles memresp_rdy stays low in RESP.
    task automatic txn(input int d, input logic [2:0] t, input logic [7:0] op,
                       input logic [31:0] a, input logic [1:0] ln, input logic [31:0] dat,
                       input int hold, output logic [31:0] got);
        mem_resp_4B_t exp_msg;
        mem_req_4B_t  m;
        int           n;
        exp_msg        = '0;
        exp_msg.type_  = t;
        exp_msg.opaque = op;
        exp_msg.len    = ln;
        exp_msg.data   = (t == TypeRead) ? model_read(d, a, ln) : 32'd0;

        n = 0;
        while (!req_rdy[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("req_rdy_idle", 64'(req_rdy[d]), 64'd1);
        m.type_ = t; m.opaque = op; m.addr = a; m.len = ln; m.data = dat;
        req_msg[d]  = m;
        req_val[d]  = 1'b1;
        resp_rdy[d] = (hold == 0);
        @(posedge clk);
        if (t == TypeWrite || t == TypeInit) model_write(d, a, ln, dat);
        @(negedge clk);
        last_acc[d] = cyc;
        // Junk write kept valid while busy; it must never be accepted.
        m.type_ = TypeWrite; m.opaque = 8'(($urandom)); m.addr = $urandom & 32'hFFFF_FC3C;
        m.len = 2'(($urandom)); m.data = $urandom;
        req_msg[d] = m;

        n = 1;
        while (!resp_val[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("resp_latency", 64'(n), 64'(lat[d] + 1));
        check_eq("resp_msg", 64'(resp_msg[d]), 64'(exp_msg));
        check_eq("req_rdy_busy", 64'(req_rdy[d]), 64'd0);
        got = resp_msg[d].data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("hold_val", 64'(resp_val[d]), 64'd1);
            check_eq("hold_msg", 64'(resp_msg[d]), 64'(exp_msg));
            check_eq("hold_req_rdy", 64'(req_rdy[d]), 64'd0);
        end
        resp_rdy[d] = 1'b1;
        @(negedge clk);
        req_val[d] = 1'b0;
        check_eq("resp_done", 64'(resp_val[d]), 64'd0);
        check_eq("req_rdy_back", 64'(req_rdy[d]), 64'd1);
        resp_rdy[d] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] a;
        logic [31:0] r;
        logic [2:0]  t;
        int          d;
        int          sel;
        int          hold;
        int          prev;
        int          seen;

        for (int i = 0; i < 2; i++) begin
            req_val[i]  = 1'b0;
            req_msg[i]  = '0;
            resp_rdy[i] = 1'b0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_eq("rst_req_rdy", 64'(req_rdy[i]), 64'd0);
            check_eq("rst_resp_val", 64'(resp_val[i]), 64'd0);
            check_eq("rst_resp_msg", 64'(resp_msg[i]), 64'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        check_eq("post_rst_rdy0", 64'(req_rdy[0]), 64'd1);
        check_eq("post_rst_rdy1", 64'(req_rdy[1]), 64'd1);

        // Give the words used below known contents.
        for (int i = 0; i < 2; i++) begin
            for (int w = 0; w < 16; w++) begin
                txn(i, TypeInit, 8'(w), 32'(w * 4), 2'd0, $urandom, 0, got);
            end
        end

        // Full-word write then read
        txn(0, TypeWrite, 8'h05, 32'h1000, 2'd0, 32'hDEADBEEF, 0, got);
        check_eq("wr_resp_data", 64'(got), 64'd0);
        txn(0, TypeRead, 8'h06, 32'h1000, 2'd0, 32'd0, 0, got);
        check_eq("rd_full", 64'(got), 64'hDEADBEEF);

        // Sub-word write and unaligned reads
        txn(0, TypeWrite, 8'h07, 32'h1002, 2'd1, 32'h0000_00AA, 0, got);
        txn(0, TypeRead, 8'h08, 32'h1000, 2'd0, 32'd0, 0, got);
        check_eq("rd_after_byte_wr", 64'(got), 64'hDEAABEEF);
        txn(0, TypeRead, 8'h09, 32'h1001, 2'd2, 32'd0, 0, got);
        check_eq("rd_half_off1", 64'(got), 64'h0000AABE);

        // Response back-pressure
        txn(0, TypeRead, 8'h0A, 32'h1000, 2'd0, 32'd0, 5, got);
        check_eq("rd_backpressure", 64'(got), 64'hDEAABEEF);

        // Address aliasing above the index bits
        txn(0, TypeWrite, 8'h0B, 32'h0000_0004, 2'd0, 32'h0000_0011, 0, got);
        txn(0, TypeRead, 8'h0C, 32'h0000_0404, 2'd0, 32'd0, 0, got);
        check_eq("rd_alias", 64'(got), 64'h0000_0011);

        // Zero latency, back-to-back every two cycles
        txn(1, TypeWrite, 8'h20, 32'h0000_0008, 2'd0, 32'hCAFE_F00D, 0, got);
        for (int i = 0; i < 5; i++) begin
            prev = last_acc[1];
            txn(1, (i % 2 == 0) ? TypeRead : TypeWrite, 8'(8'h21 + i), 32'h0000_0008,
                2'(i), $urandom, 0, got);
            check_eq("b2b_spacing", 64'(last_acc[1] - prev), 64'd2);
        end

        // Randomized traffic on both instances
        for (int i = 0; i < 120; i++) begin
            d   = $urandom_range(0, 1);
            sel = $urandom_range(0, 9);
            if (sel < 4)      t = TypeRead;
            else if (sel < 6) t = TypeWrite;
            else if (sel < 8) t = TypeInit;
            else              t = 3'($urandom_range(3, 7));
            r    = $urandom;
            a    = {r[31:10], 4'b0000, 4'($urandom_range(0, 15)), r[1:0]};
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            txn(d, t, 8'($urandom), a, 2'($urandom), $urandom, hold, got);
        end

        // Reset during WAIT of a read
        r = 32'h0000_0008;
        req_msg[0].type_  = TypeRead;
        req_msg[0].opaque = 8'h77;
        req_msg[0].addr   = r;
        req_msg[0].len    = 2'd0;
        req_msg[0].data   = 32'd0;
        resp_rdy[0] = 1'b1;
        while (!req_rdy[0]) @(negedge clk);
        req_val[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_val[0] = 1'b0;
        check_eq("in_wait_val", 64'(resp_val[0]), 64'd0);
        #1 reset = 1'b0;
        #1;
        check_eq("async_rst_rdy", 64'(req_rdy[0]), 64'd0);
        check_eq("async_rst_val", 64'(resp_val[0]), 64'd0);
        check_eq("async_rst_msg", 64'(resp_msg[0]), 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("rel_rdy0", 64'(req_rdy[0]), 64'd1);
        check_eq("rel_rdy1", 64'(req_rdy[1]), 64'd1);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (resp_val[0]) seen = 1;
        end
        check_eq("no_stale_resp", 64'(seen), 64'd0);
        resp_rdy[0] = 1'b0;
        txn(0, TypeRead, 8'h31, 32'h1000, 2'd0, 32'd0, 0, got);
        check_eq("persist_after_rst", 64'(got), 64'(model[0][0]));
        txn(1, TypeRead, 8'h32, 32'h0000_0008, 2'd0, 32'd0, 0, got);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/lab3_cache_mem_responder.md
LAB3_CACHE_MEM_RESPONDER -- requirements
Module: lab3_cache_MemResponder

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 256, meaning words of backing storage (power of two, >=2).
REQ-002 SHALL have parameter LATENCY, default 2, meaning extra wait cycles between request accept and response valid (0..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port memreq_val  input  1  request valid from requester.
REQ-006 SHALL have port memreq_rdy  output  1  responder can accept a request.
REQ-007 SHALL have port memreq_msg  input  mem_req_4B_t  fields type, opaque, addr, len, data.
REQ-008 SHALL have port memresp_val  output  1  response valid.
REQ-009 SHALL have port memresp_rdy  input  1  requester can accept the response.
REQ-010 SHALL have port memresp_msg  output  mem_resp_4B_t  fields type, opaque, test, len, data.

Function
REQ-011 SHALL implement FSM states IDLE, WAIT, RESP; memreq_rdy=1 only in IDLE; memresp_val=1 only in RESP; both driven from state only.
REQ-012 SHALL accept a request on the rising edge where memreq_val && memreq_rdy, latching type, opaque, addr, len.
REQ-013 SHALL transition IDLE->WAIT on accept with wait counter loaded to LATENCY-1 when LATENCY>=1; IDLE->RESP on accept when LATENCY=0.
REQ-014 SHALL decrement the counter each WAIT cycle and move WAIT->RESP in the cycle after the counter reads 0; response valid exactly LATENCY+1 cycles after accept edge.
REQ-015 SHALL hold memresp_msg stable in RESP until memresp_val && memresp_rdy, then move RESP->IDLE; no request is accepted in the RESP cycle (one outstanding request, blocking).
REQ-016 SHALL index storage by addr[2 +: log2(NUM_WORDS)]; upper address bits ignored (aliasing wrap-around).
REQ-017 SHALL decode len as bytes: 0->4, 1->1, 2->2, 3->3; byte offset = addr[1:0].
REQ-018 SHALL, for WRITE and INIT, update bytes offset..offset+nbytes-1 of the indexed word at the accept edge; bytes beyond byte 3 are dropped, other bytes unchanged.
REQ-019 SHALL, for READ, capture at the accept edge the indexed word shifted right by 8*offset and masked to nbytes; upper bytes zero.
REQ-020 SHALL return response type = request type, opaque = request opaque, test = 0, len = request len, data = captured read data for READ, 0 otherwise.
REQ-021 SHALL treat any other type (AMO etc.) as no-op on storage, responding per REQ-020 with data 0.
REQ-022 SHALL make a write visible to any request accepted afterwards (back-to-back write then read returns new data).
REQ-023 SHALL ignore memreq_msg when not accepting and memresp_rdy when not in RESP.

Reset
REQ-024 SHALL, while reset=0 (asynchronously), force state IDLE, counter 0, memresp_val=0, memreq_rdy=0, and latched message fields 0.
REQ-025 SHALL raise memreq_rdy in the first cycle after reset deasserts.
REQ-026 SHALL drop any in-flight request on reset without producing a response; storage contents are not reset and a write already accepted persists.

Verification
REQ-027 SHALL cover: LATENCY=2, WRITE addr 0x1000 len 0 data 0xDEADBEEF opaque 0x05 -> resp val 3 cycles after accept, type WRITE, opaque 0x05, data 0; then READ 0x1000 -> data 0xDEADBEEF.
REQ-028 SHALL cover: after REQ-027, WRITE addr 0x1002 len 1 data 0x000000AA, READ 0x1000 len 0 -> 0xDEAABEEF; READ 0x1001 len 2 -> 0x0000AABE.
REQ-029 SHALL cover: memresp_rdy held 0 for 5 cycles in RESP -> memresp_val stays 1, msg unchanged, memreq_rdy stays 0; accept occurs cycle after rdy=1 handshake.
REQ-030 SHALL cover: NUM_WORDS=256, WRITE addr 0x00000004 data 0x11, READ addr 0x00000404 -> 0x00000011 (alias).
REQ-031 SHALL cover: LATENCY=0 -> resp val cycle after accept; back-to-back requests every 2 cycles with memresp_rdy=1.
REQ-032 SHALL cover: reset pulsed during WAIT of a READ -> no response ever issued for it, memreq_rdy=1 first cycle after release, prior writes readable.
